// File: rtl/pcs_tx_sequencer.sv
// PCS transmit sequencer: paces the 64b/66b encoder and scrambler and
// produces the gearbox sequence count with its periodic two-cycle pause.
// Each block is two 32-bit words; PAUSE_SEQ blocks are followed by a pause.
module pcs_tx_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PAUSE_SEQ  = 32
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic        i_data_valid,
    input  logic        i_clear_err,
    output logic        o_ready,
    output logic        o_scr_valid,
    output logic        o_header_phase,
    output logic [5:0]  o_seq,
    output logic        o_pause,
    output logic        o_underrun,
    output logic [31:0] o_block_count
);

    // The datapath word is fixed at 32 bits, and the sequence count must fit
    // in the 6-bit o_seq port.
    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("pcs_tx_sequencer: DATA_WIDTH must be 32");
    end
    if ((PAUSE_SEQ < 1) || (PAUSE_SEQ > 63)) begin : g_bad_pause_seq
        $error("pcs_tx_sequencer: PAUSE_SEQ must be in 1..63");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [5:0] SEQ_LAST  = 6'(PAUSE_SEQ - 1);
    localparam logic [5:0] SEQ_PAUSE = 6'(PAUSE_SEQ);

    state_e      state_q, state_d;
    logic        half_q, half_d;
    logic [5:0]  seq_q, seq_d;
    // Set on the first edge after reset release; IDLE waits for it so that
    // RUN is entered on the second edge after release.
    logic        armed_q;
    logic        underrun_q, underrun_d;
    logic [31:0] block_count_q, block_count_d;
    logic        underrun_set;
    logic        block_done;

    // State register: FSM state, word half and sequence count
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            half_q  <= 1'b0;
            seq_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            seq_q   <= seq_d;
            armed_q <= 1'b1;
        end
    end

    // Next-state logic: enable is only honoured at a block boundary
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        seq_d   = seq_q;
        case (state_q)
            ST_IDLE: begin
                half_d = 1'b0;
                seq_d  = '0;
                if (armed_q && i_enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!half_q) begin
                    // First word: the block always completes.
                    half_d = 1'b1;
                end else if (!i_enable) begin
                    state_d = ST_IDLE;
                    half_d  = 1'b0;
                    seq_d   = '0;
                end else if (seq_q == SEQ_LAST) begin
                    state_d = ST_PAUSE;
                    half_d  = 1'b0;
                    seq_d   = SEQ_PAUSE;
                end else begin
                    half_d = 1'b0;
                    seq_d  = seq_q + 6'd1;
                end
            end
            ST_PAUSE: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                    half_d  = 1'b0;
                    seq_d   = '0;
                end else if (!half_q) begin
                    half_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    half_d  = 1'b0;
                    seq_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                half_d  = 1'b0;
                seq_d   = '0;
            end
        endcase
    end

    // Moore outputs decoded from registered state only
    always_comb begin
        o_ready        = 1'b0;
        o_pause        = 1'b0;
        o_header_phase = 1'b0;
        case (state_q)
            ST_RUN: begin
                o_ready        = 1'b1;
                o_header_phase = ~half_q;
            end
            ST_PAUSE: begin
                o_pause = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_seq       = seq_q;
    assign o_scr_valid = o_ready & i_data_valid;

    // Sticky underrun and block counter next-state; a new underrun beats a clear
    always_comb begin
        underrun_set  = o_ready & ~i_data_valid;
        block_done    = (state_q == ST_RUN) && half_q && i_data_valid;
        underrun_d    = underrun_q;
        block_count_d = block_count_q;
        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (i_clear_err) begin
            underrun_d = 1'b0;
        end
        if (block_done) begin
            block_count_d = block_count_q + 32'd1;
        end
    end

    // Status registers: sticky underrun flag and wrapping block counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            underrun_q    <= 1'b0;
            block_count_q <= '0;
        end else begin
            underrun_q    <= underrun_d;
            block_count_q <= block_count_d;
        end
    end

    assign o_underrun    = underrun_q;
    assign o_block_count = block_count_q;

endmodule

// File: tb/tb_pcs_tx_sequencer.sv
// Directed bench for pcs_tx_sequencer: a table of per-cycle vectors followed
// by hand-written sequences for the pause period, enable drop in pause,
// counter wrap and asynchronous reset in pause.
module tb_pcs_tx_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_data_valid = 1'b0;
    logic        i_clear_err = 1'b0;
    logic        o_ready;
    logic        o_scr_valid;
    logic        o_header_phase;
    logic [5:0]  o_seq;
    logic        o_pause;
    logic        o_underrun;
    logic [31:0] o_block_count;

    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    pcs_tx_sequencer #(
        .DATA_WIDTH (32),
        .PAUSE_SEQ  (32)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_enable       (i_enable),
        .i_data_valid   (i_data_valid),
        .i_clear_err    (i_clear_err),
        .o_ready        (o_ready),
        .o_scr_valid    (o_scr_valid),
        .o_header_phase (o_header_phase),
        .o_seq          (o_seq),
        .o_pause        (o_pause),
        .o_underrun     (o_underrun),
        .o_block_count  (o_block_count)
    );

    // flags = {en, dv, clr, ready, pause, hdr, scr, und}
    typedef struct {
        logic [7:0]  flags;
        logic [5:0]  seq;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(o_ready), 0);
        check({tag, "_pause"}, 32'(o_pause), 0);
        check({tag, "_hdr"},   32'(o_header_phase), 0);
        check({tag, "_scr"},   32'(o_scr_valid), 0);
        check({tag, "_seq"},   32'(o_seq), 0);
        check({tag, "_und"},   32'(o_underrun), 0);
        check({tag, "_cnt"},   o_block_count, 0);
    endtask

    // Position k within the 66-cycle period: 64 ready cycles then 2 pause cycles
    task automatic check_pos(input int p, input int k, input int cnt0);
        int exp_run;
        int exp_seq;
        exp_run = (k < 64) ? 1 : 0;
        exp_seq = (k < 64) ? k / 2 : 32;
        check($sformatf("ss_p%0d_k%0d_ready", p, k), 32'(o_ready), exp_run);
        check($sformatf("ss_p%0d_k%0d_scr", p, k), 32'(o_scr_valid), exp_run);
        check($sformatf("ss_p%0d_k%0d_pause", p, k), 32'(o_pause), 1 - exp_run);
        check($sformatf("ss_p%0d_k%0d_hdr", p, k), 32'(o_header_phase),
              (exp_run == 1 && (k % 2) == 0) ? 1 : 0);
        check($sformatf("ss_p%0d_k%0d_seq", p, k), 32'(o_seq), exp_seq);
        check($sformatf("ss_p%0d_k%0d_cnt", p, k), o_block_count, cnt0 + exp_seq);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;

        vecs[0]  = '{8'b110_00000, 6'd0, 32'd0};
        vecs[1]  = '{8'b110_00000, 6'd0, 32'd0};
        vecs[2]  = '{8'b110_10110, 6'd0, 32'd0};
        vecs[3]  = '{8'b110_10010, 6'd0, 32'd0};
        vecs[4]  = '{8'b110_10110, 6'd1, 32'd1};
        vecs[5]  = '{8'b100_10000, 6'd1, 32'd1};
        vecs[6]  = '{8'b110_10111, 6'd2, 32'd1};
        vecs[7]  = '{8'b111_10011, 6'd2, 32'd1};
        vecs[8]  = '{8'b101_10100, 6'd3, 32'd2};
        vecs[9]  = '{8'b110_10011, 6'd3, 32'd2};
        vecs[10] = '{8'b111_10111, 6'd4, 32'd3};
        vecs[11] = '{8'b110_10010, 6'd4, 32'd3};
        vecs[12] = '{8'b010_10110, 6'd5, 32'd4};
        vecs[13] = '{8'b010_10010, 6'd5, 32'd4};
        vecs[14] = '{8'b010_00000, 6'd0, 32'd5};
        vecs[15] = '{8'b110_00000, 6'd0, 32'd5};
        vecs[16] = '{8'b110_10110, 6'd0, 32'd5};

        // Reset held with enable and data valid high
        i_enable     = 1'b1;
        i_data_valid = 1'b1;
        repeat (2) @(negedge i_clk);
        #1;
        check_all_zero("rst");
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Table: release, startup latency, underrun/clear, enable drop at seq 5
        for (int i = 0; i < 17; i++) begin
            i_enable     = vecs[i].flags[7];
            i_data_valid = vecs[i].flags[6];
            i_clear_err  = vecs[i].flags[5];
            #1;
            check($sformatf("v%0d_ready", i), 32'(o_ready), 32'(vecs[i].flags[4]));
            check($sformatf("v%0d_pause", i), 32'(o_pause), 32'(vecs[i].flags[3]));
            check($sformatf("v%0d_hdr", i),   32'(o_header_phase), 32'(vecs[i].flags[2]));
            check($sformatf("v%0d_scr", i),   32'(o_scr_valid), 32'(vecs[i].flags[1]));
            check($sformatf("v%0d_und", i),   32'(o_underrun), 32'(vecs[i].flags[0]));
            check($sformatf("v%0d_seq", i),   32'(o_seq), 32'(vecs[i].seq));
            check($sformatf("v%0d_cnt", i),   o_block_count, vecs[i].cnt);
            @(negedge i_clk);
        end
        i_clear_err = 1'b0;

        // Steady state: vector 16 was k=0 of period 0 with 5 blocks done
        for (int p = 0; p < 2; p++) begin
            for (int k = (p == 0) ? 1 : 0; k < 66; k++) begin
                #1;
                check_pos(p, k, 5 + 32 * p);
                @(negedge i_clk);
            end
        end

        // Third period: drop enable on the first pause cycle
        for (int k = 0; k < 65; k++) begin
            if (k == 64) i_enable = 1'b0;
            #1;
            check_pos(2, k, 69);
            @(negedge i_clk);
        end
        #1;
        check("pdrop_ready", 32'(o_ready), 0);
        check("pdrop_pause", 32'(o_pause), 0);
        check("pdrop_seq", 32'(o_seq), 0);
        check("pdrop_cnt", o_block_count, 101);
        i_enable = 1'b1;
        @(negedge i_clk);
        #1;
        check("reen_ready", 32'(o_ready), 1);
        check("reen_hdr", 32'(o_header_phase), 1);
        check("reen_seq", 32'(o_seq), 0);

        // Counter wrap: preload all ones on a first-word cycle
        force dut.block_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.block_count_q;
        check("wrap_pre", o_block_count, 32'hFFFF_FFFF);
        @(negedge i_clk);
        #1;
        check("wrap_half1", o_block_count, 32'hFFFF_FFFF);
        @(negedge i_clk);
        #1;
        check("wrap_zero", o_block_count, 32'h0000_0000);
        check("wrap_seq", 32'(o_seq), 1);

        // Asynchronous reset in the middle of a pause cycle
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge i_clk);
            if (o_pause) found = 1'b1;
        end
        check("pause_reached", 32'(found), 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check_all_zero("arst");
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        #1;
        check("rel1_ready", 32'(o_ready), 0);
        @(negedge i_clk);
        #1;
        check("rel2_ready", 32'(o_ready), 1);
        check("rel2_hdr", 32'(o_header_phase), 1);
        check("rel2_seq", 32'(o_seq), 0);
        check("rel2_cnt", o_block_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
